// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory data port between two requesters. Each access passes
// through a three-state FSM: IDLE accepts one request, BUSY drives the memory
// command until mem_done or a timeout, and RESP returns a one-cycle response
// to the requester that owns the transaction.
//
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - on contention, grant the requester that did not win last time
//   undefined - on contention, requester 0 always wins (fixed priority)
//
// Parameter: TIMEOUT (1..255) - BUSY cycles without mem_done before abort.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   reqN_valid/ready                request handshake, N = 0,1
//   reqN_we/ctrl/addr/wdata         request command ({is_unsign, size[1:0]})
//   respN_valid/rdata/error         one-cycle response to requester N
//   mem_enable/write_en/ctrl/addr/wdata   memory command (live in BUSY only)
//   mem_rdata/error/done            memory response
//   busy                            FSM not in IDLE
//   grant_id                        owner of the current or last transaction
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [2:0]  req0_ctrl,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [2:0]  req1_ctrl,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        resp0_valid,
    output logic [31:0] resp0_rdata,
    output logic        resp0_error,
    output logic        resp1_valid,
    output logic [31:0] resp1_rdata,
    output logic        resp1_error,
    output logic        mem_enable,
    output logic        mem_write_en,
    output logic [2:0]  mem_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    input  logic        mem_done,
    output logic        busy,
    output logic        grant_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_cap_q, rdata_cap_d;
    logic        err_cap_q, err_cap_d;
    logic        grant_q, grant_d;

    logic        gsel_s;
    logic        idle_s;
    logic        accept_s;
    logic [31:0] resp_data_s;

    logic        resp0_valid_q, resp1_valid_q;
    logic [31:0] resp0_rdata_q, resp1_rdata_q;
    logic        resp0_error_q, resp1_error_q;
    logic        mem_enable_q, mem_write_en_q;
    logic [2:0]  mem_ctrl_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        busy_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_q;

    // Last-grant pointer: remembers the winner of the most recent accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept_s) begin
            last_q <= gsel_s;
        end else begin
            last_q <= last_q;
        end
    end
`endif

    // Arbitration: pick which requester may be accepted this cycle.
    always_comb begin
        gsel_s = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            gsel_s = ~last_q;
`else
            gsel_s = 1'b0;
`endif
        end else if (req1_valid) begin
            gsel_s = 1'b1;
        end else begin
            gsel_s = 1'b0;
        end
    end

    // Ready is a same-cycle handshake, so it stays combinational; it is held
    // low during reset so every output reads 0 while rst is asserted.
    assign idle_s     = (state_q == S_IDLE) && !rst;
    assign req0_ready = idle_s && !gsel_s;
    assign req1_ready = idle_s && gsel_s;
    assign accept_s   = gsel_s ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

    // Next-state, command latch, response capture and timeout counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_cap_d = rdata_cap_q;
        err_cap_d   = err_cap_q;
        grant_d     = grant_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_BUSY;
                    cnt_d   = 8'd0;
                    grant_d = gsel_s;
                    we_d    = gsel_s ? req1_we    : req0_we;
                    ctrl_d  = gsel_s ? req1_ctrl  : req0_ctrl;
                    addr_d  = gsel_s ? req1_addr  : req0_addr;
                    wdata_d = gsel_s ? req1_wdata : req0_wdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mem_done) begin
                    state_d     = S_RESP;
                    rdata_cap_d = mem_rdata;
                    err_cap_d   = mem_error;
                end else if ((cnt_q + 8'd1) == TIMEOUT_C) begin
                    // This is the TIMEOUT-th BUSY cycle without completion.
                    state_d     = S_RESP;
                    cnt_d       = cnt_q + 8'd1;
                    rdata_cap_d = 32'd0;
                    err_cap_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Reads return captured data; writes and failed accesses return 0.
        if (!we_d && !err_cap_d) begin
            resp_data_s = rdata_cap_d;
        end else begin
            resp_data_s = 32'd0;
        end
    end

    // State, datapath and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            we_q           <= 1'b0;
            ctrl_q         <= 3'd0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            rdata_cap_q    <= 32'd0;
            err_cap_q      <= 1'b0;
            grant_q        <= 1'b0;
            mem_enable_q   <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_ctrl_q     <= 3'd0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp0_rdata_q  <= 32'd0;
            resp1_rdata_q  <= 32'd0;
            resp0_error_q  <= 1'b0;
            resp1_error_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            ctrl_q         <= ctrl_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_cap_q    <= rdata_cap_d;
            err_cap_q      <= err_cap_d;
            grant_q        <= grant_d;
            mem_enable_q   <= (state_d == S_BUSY);
            mem_write_en_q <= (state_d == S_BUSY) && we_d;
            mem_ctrl_q     <= (state_d == S_BUSY) ? ctrl_d  : 3'd0;
            mem_addr_q     <= (state_d == S_BUSY) ? addr_d  : 32'd0;
            mem_wdata_q    <= (state_d == S_BUSY) ? wdata_d : 32'd0;
            resp0_valid_q  <= (state_d == S_RESP) && !grant_d;
            resp1_valid_q  <= (state_d == S_RESP) && grant_d;
            resp0_rdata_q  <= ((state_d == S_RESP) && !grant_d) ? resp_data_s : 32'd0;
            resp1_rdata_q  <= ((state_d == S_RESP) && grant_d)  ? resp_data_s : 32'd0;
            resp0_error_q  <= (state_d == S_RESP) && !grant_d && err_cap_d;
            resp1_error_q  <= (state_d == S_RESP) && grant_d && err_cap_d;
            busy_q         <= (state_d != S_IDLE);
        end
    end

    assign mem_enable   = mem_enable_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_ctrl     = mem_ctrl_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign resp0_valid  = resp0_valid_q;
    assign resp0_rdata  = resp0_rdata_q;
    assign resp0_error  = resp0_error_q;
    assign resp1_valid  = resp1_valid_q;
    assign resp1_rdata  = resp1_rdata_q;
    assign resp1_error  = resp1_error_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we;
    logic [2:0]  req0_ctrl;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [2:0]  req1_ctrl;
    logic [31:0] req1_addr, req1_wdata;
    logic        resp0_valid, resp0_error, resp1_valid, resp1_error;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        mem_enable, mem_write_en, mem_error, mem_done;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, grant_id;

    // memory model controls
    logic        mem_hold;
    logic        mem_force_done;
    logic        rd_pend_q;
    logic [7:0]  mem_arr [0:255];
    logic [7:0]  ma0, ma1, ma2, ma3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_ctrl(req0_ctrl), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_ctrl(req1_ctrl), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_error(resp0_error),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_error(resp1_error),
        .mem_enable(mem_enable), .mem_write_en(mem_write_en), .mem_ctrl(mem_ctrl),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_error(mem_error), .mem_done(mem_done), .busy(busy), .grant_id(grant_id)
    );

    // Memory: writes complete combinationally, reads one cycle later.
    assign ma0 = mem_addr[7:0];
    assign ma1 = mem_addr[7:0] + 8'd1;
    assign ma2 = mem_addr[7:0] + 8'd2;
    assign ma3 = mem_addr[7:0] + 8'd3;

    function automatic logic [31:0] load_val(input logic [2:0] ctrl,
                                             input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
        case (ctrl[1:0])
            2'b00:   return ctrl[2] ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'b01:   return ctrl[2] ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    assign mem_rdata = load_val(mem_ctrl, mem_arr[ma0], mem_arr[ma1], mem_arr[ma2], mem_arr[ma3]);
    assign mem_error = mem_enable & mem_addr[31];
    assign mem_done  = mem_force_done | (!mem_hold & mem_enable & (mem_write_en | rd_pend_q));

    always_ff @(posedge clk) begin
        if (rst) rd_pend_q <= 1'b0;
        else     rd_pend_q <= mem_enable & ~mem_write_en & ~rd_pend_q & ~mem_hold;
    end

    always @(posedge clk) begin
        if (mem_enable && mem_write_en && mem_done) begin
            case (mem_ctrl[1:0])
                2'b00: mem_arr[ma0] <= mem_wdata[7:0];
                2'b01: begin
                    mem_arr[ma0] <= mem_wdata[7:0];
                    mem_arr[ma1] <= mem_wdata[15:8];
                end
                default: begin
                    mem_arr[ma0] <= mem_wdata[7:0];
                    mem_arr[ma1] <= mem_wdata[15:8];
                    mem_arr[ma2] <= mem_wdata[23:16];
                    mem_arr[ma3] <= mem_wdata[31:24];
                end
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE. lat counts edges from accept edge T to the
    // edge at which the response is visible (write 2, read 3).
    task automatic txn(input string tag, input logic id, input logic we,
                       input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat,
                       output logic [31:0] rdata, output logic err, output logic other,
                       output logic en_t, output logic we_t, output logic [31:0] addr_t,
                       output logic [31:0] wdata_t);
        lat = 0; rdata = 32'd0; err = 1'b0; other = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_we = we; req1_ctrl = ctrl; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_we = we; req0_ctrl = ctrl; req0_addr = addr; req0_wdata = wdata;
        end
        #1;
        check_eq({tag, "_rdy"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        en_t = mem_enable; we_t = mem_write_en; addr_t = mem_addr; wdata_t = mem_wdata;
        other = id ? resp0_valid : resp1_valid;
        for (int i = 1; i <= 40; i++) begin
            tick();
            other = other | (id ? resp0_valid : resp1_valid);
            if (id ? resp1_valid : resp0_valid) begin
                lat = i + 1;
                rdata = id ? resp1_rdata : resp0_rdata;
                err = id ? resp1_error : resp0_error;
                break;
            end
        end
        tick();
        check_eq({tag, "_pulse"}, {31'd0, id ? resp1_valid : resp0_valid}, 32'd0);
    endtask

    task automatic wait_busy(input logic lvl, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd, at, wt;
        logic        er, oth, et, wet, ok, seen;
        logic [3:0]  gseq;

        rst = 1'b1; mem_hold = 1'b0; mem_force_done = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_ctrl = 3'd0; req0_addr = 32'd0; req0_wdata = 32'd0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_ctrl = 3'd0; req1_addr = 32'd0; req1_wdata = 32'd0;
        tick(); tick();
        check_eq("rst_outs", {27'd0, busy, mem_enable, resp0_valid, resp1_valid, grant_id}, 32'd0);
        check_eq("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready0", {31'd0, req0_ready}, 32'd1);

        // req1 byte write 0x80 to 0x13
        txn("wr_b", 1'b1, 1'b1, 3'b000, 32'h13, 32'h80, lat, rd, er, oth, et, wet, at, wt);
        check_eq("wr_b_lat", 32'(lat), 32'd2);
        check_eq("wr_b_err", {31'd0, er}, 32'd0);
        check_eq("wr_b_gid", {31'd0, grant_id}, 32'd1);

        // req1 signed byte read at 0x13
        txn("rd_sb", 1'b1, 1'b0, 3'b000, 32'h13, 32'd0, lat, rd, er, oth, et, wet, at, wt);
        check_eq("rd_sb_cmd", {30'd0, et, wet}, 32'd2);
        check_eq("rd_sb_lat", 32'(lat), 32'd3);
        check_eq("rd_sb_data", rd, 32'hFFFF_FF80);
        check_eq("rd_sb_other", {31'd0, oth}, 32'd0);

        // req0 word write 0xDEADBEEF to 0x10
        txn("wr_w", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat, rd, er, oth, et, wet, at, wt);
        check_eq("wr_w_cmd", {30'd0, et, wet}, 32'd3);
        check_eq("wr_w_addr", at, 32'h10);
        check_eq("wr_w_wdata", wt, 32'hDEAD_BEEF);
        check_eq("wr_w_lat", 32'(lat), 32'd2);
        check_eq("wr_w_err", {31'd0, er}, 32'd0);
        check_eq("wr_w_rdata", rd, 32'd0);

        // half-word reads at 0x12
        txn("rd_uh", 1'b0, 1'b0, 3'b101, 32'h12, 32'd0, lat, rd, er, oth, et, wet, at, wt);
        check_eq("rd_uh_data", rd, 32'h0000_DEAD);
        txn("rd_sh", 1'b0, 1'b0, 3'b001, 32'h12, 32'd0, lat, rd, er, oth, et, wet, at, wt);
        check_eq("rd_sh_data", rd, 32'hFFFF_DEAD);

        // memory error on read: error flagged, data forced to 0
        txn("rd_err", 1'b0, 1'b0, 3'b010, 32'h8000_0010, 32'd0, lat, rd, er, oth, et, wet, at, wt);
        check_eq("rd_err_err", {31'd0, er}, 32'd1);
        check_eq("rd_err_data", rd, 32'd0);

        // timeout: mem_done never arrives
        mem_hold = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_ctrl = 3'b010; req0_addr = 32'h40;
        tick();
        req0_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp0_valid) break;
            if (mem_enable) lat++;
            tick();
        end
        check_eq("to_busy_cycles", 32'(lat), 32'd15);
        check_eq("to_valid", {31'd0, resp0_valid}, 32'd1);
        check_eq("to_err", {31'd0, resp0_error}, 32'd1);
        check_eq("to_rdata", resp0_rdata, 32'd0);
        check_eq("to_en_off", {31'd0, mem_enable}, 32'd0);
        tick();
        mem_hold = 1'b0;

        // mem_done in IDLE is ignored
        mem_force_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | busy | resp0_valid | resp1_valid;
        end
        mem_force_done = 1'b0;
        check_eq("idle_done_ign", {31'd0, seen}, 32'd0);

        // reset during BUSY of a read abandons it
        req1_valid = 1'b1; req1_we = 1'b0; req1_ctrl = 3'b000; req1_addr = 32'h13;
        tick();
        req1_valid = 1'b0;
        check_eq("rb_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check_eq("rb_outs", {28'd0, busy, mem_enable, resp0_valid, resp1_valid}, 32'd0);
        check_eq("rb_addr", mem_addr, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | resp0_valid | resp1_valid;
        end
        check_eq("rb_no_resp", {31'd0, seen}, 32'd0);
        txn("rb_new", 1'b0, 1'b1, 3'b010, 32'h30, 32'h1234_5678, lat, rd, er, oth, et, wet, at, wt);
        check_eq("rb_new_lat", 32'(lat), 32'd2);

        // contention: both requesters valid for four transactions
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_ctrl = 3'b010; req0_addr = 32'h20; req0_wdata = 32'h1;
        req1_valid = 1'b1; req1_we = 1'b1; req1_ctrl = 3'b010; req1_addr = 32'h24; req1_wdata = 32'h2;
        gseq = 4'd0;
        for (int k = 0; k < 4; k++) begin
            wait_busy(1'b1, ok);
            check_eq("arb_accept", {31'd0, ok}, 32'd1);
            gseq[k] = grant_id;
            if (k == 0) check_eq("arb_busy_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            tick();
            wait_busy(1'b0, ok);
            check_eq("arb_done", {31'd0, ok}, 32'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check_eq("arb_order", {28'd0, gseq}, 32'hA);
`else
        check_eq("arb_order", {28'd0, gseq}, 32'h0);
`endif
        tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
